// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: delay line + coefficient bank that walks one tap per clock
// and presents sample/coefficient pairs with first/last framing to the MAC ALU.
module fir_tap_sequencer #(
    parameter int NTAPS = 8,
    parameter int DW = 16,
    parameter int AW = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_sample,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [DW-1:0] coef_wdata,
    output logic [DW-1:0] X,
    output logic [DW-1:0] B,
    output logic          mac_valid,
    output logic          mac_first,
    output logic          mac_last,
    output logic          busy
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] dl [NTAPS];
    logic [DW-1:0] cf [NTAPS];
    logic run, at_last, xfer;
    assign run = state == RUN;
    assign at_last = cnt == AW'(NTAPS - 1);
    // ready is gated by rst_n so it drops immediately on an asynchronous reset
    assign in_ready = rst_n && (!run || at_last);
    assign xfer = in_valid && in_ready;
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        if (xfer) begin
            state_nxt = RUN;
            cnt_nxt = '0;
        end else if (run) begin
            state_nxt = at_last ? IDLE : RUN;
            cnt_nxt = at_last ? '0 : cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                dl[i] <= '0;
                cf[i] <= '0;
            end
        end else begin
            if (xfer) begin
                for (int i = NTAPS - 1; i > 0; i--)
                    dl[i] <= dl[i-1];
                dl[0] <= in_sample;
            end
            // the bank is frozen while taps are being walked
            if (coef_we && !run)
                cf[coef_addr] <= coef_wdata;
        end
    assign X = run ? dl[cnt] : '0;
    assign B = run ? cf[cnt] : '0;
    assign mac_valid = run;
    assign mac_first = run && cnt == '0;
    assign mac_last = run && at_last;
    assign busy = run;
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: table vectors, directed corner sequences and a
// queue-based reference model checked every cycle under random stimulus.
module tb_fir_tap_sequencer;
    localparam int N = 8;
    localparam int DW = 16;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, coef_we = 1'b0;
    logic in_ready, mac_valid, mac_first, mac_last, busy;
    logic [DW-1:0] in_sample = '0, coef_wdata = '0, X, B;
    logic [2:0] coef_addr = '0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    fir_tap_sequencer #(.NTAPS(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sample(in_sample), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .X(X), .B(B), .mac_valid(mac_valid),
        .mac_first(mac_first), .mac_last(mac_last), .busy(busy)
    );

    // model: a queue of tap pairs still to be presented, one popped per clock
    typedef struct {logic [DW-1:0] x; logic [DW-1:0] b; logic first; logic last;} tap_t;
    tap_t pend[$];
    logic [DW-1:0] hist [N];
    logic [DW-1:0] cfm [N];

    typedef struct {
        logic v; logic [DW-1:0] s; logic we; logic [2:0] a; logic [DW-1:0] d;
        logic [DW-1:0] ex; logic [DW-1:0] eb; logic ev; logic ef; logic el; logic er;
    } vec_t;
    vec_t tbl[$];
    logic [DW-1:0] b2b [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < N; i++) begin
            hist[i] = '0;
            cfm[i] = '0;
        end
    endtask

    task automatic model_edge();
        logic xf;
        if (!rst_n) return;
        xf = in_valid && pend.size() <= 1;
        if (coef_we && pend.size() == 0) cfm[coef_addr] = coef_wdata;
        if (pend.size() > 0) pend.delete(0);
        if (xf) begin
            for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = in_sample;
            for (int k = 0; k < N; k++) pend.push_back('{hist[k], cfm[k], k == 0, k == N - 1});
        end
    endtask

    task automatic model_check();
        tap_t t;
        logic v;
        t = '{'0, '0, 1'b0, 1'b0};
        v = pend.size() > 0;
        if (v) t = pend[0];
        chk("X", 32'(X), 32'(t.x));
        chk("B", 32'(B), 32'(t.b));
        chk("mac_valid", 32'(mac_valid), 32'(v));
        chk("mac_first", 32'(mac_first), 32'(t.first));
        chk("mac_last", 32'(mac_last), 32'(t.last));
        chk("busy", 32'(busy), 32'(v));
        chk("in_ready", 32'(in_ready), 32'(rst_n && pend.size() <= 1));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic add(input logic v, input int s, input logic we, input int a, input int d,
                       input int ex, input int eb, input logic ev, input logic ef,
                       input logic el, input logic er);
        tbl.push_back('{v, DW'(s), we, 3'(a), DW'(d), DW'(ex), DW'(eb), ev, ef, el, er});
    endtask

    initial begin
        // impulse response: cf = 1..8, then sample 2 followed by seven zeros with gaps
        for (int i = 0; i < N; i++) add(1'b0, 0, 1'b1, i, i + 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < N; j++) begin
            add(1'b1, j == 0 ? 2 : 0, 1'b0, 0, 0, j == 0 ? 2 : 0, 1, 1'b1, 1'b1, 1'b0, 1'b0);
            for (int k = 1; k < N; k++)
                add(1'b0, 0, 1'b0, 0, 0, k == j ? 2 : 0, k + 1, 1'b1, 1'b0, k == N - 1, k == N - 1);
            add(1'b0, 0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        b2b[0] = 16'd10;
        b2b[1] = 16'd20;
        b2b[2] = 16'd30;

        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);
        chk("busy_after_reset", 32'(busy), 32'd0);

        foreach (tbl[i]) begin
            in_valid = tbl[i].v;
            in_sample = tbl[i].s;
            coef_we = tbl[i].we;
            coef_addr = tbl[i].a;
            coef_wdata = tbl[i].d;
            tick();
            chk("tbl_X", 32'(X), 32'(tbl[i].ex));
            chk("tbl_B", 32'(B), 32'(tbl[i].eb));
            chk("tbl_valid", 32'(mac_valid), 32'(tbl[i].ev));
            chk("tbl_first", 32'(mac_first), 32'(tbl[i].ef));
            chk("tbl_last", 32'(mac_last), 32'(tbl[i].el));
            chk("tbl_ready", 32'(in_ready), 32'(tbl[i].er));
        end
        in_valid = 1'b0;
        coef_we = 1'b0;

        begin : back_to_back
            int firsts;
            firsts = 0;
            in_valid = 1'b1;
            for (int s = 0; s < 3; s++) begin
                in_sample = b2b[s];
                for (int t = 0; t < N; t++) begin
                    tick();
                    chk("b2b_valid", 32'(mac_valid), 32'd1);
                    if (mac_first) firsts++;
                    if (s == 2 && t < 3) chk("b2b_x", 32'(X), 32'(b2b[2-t]));
                end
            end
            in_valid = 1'b0;
            chk("b2b_firsts", firsts, 32'd3);
            tick();
            chk("b2b_idle", 32'(busy), 32'd0);
        end

        // stall: offer a sample from cnt = 3 onward
        in_valid = 1'b1;
        in_sample = 16'd7;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        in_valid = 1'b1;
        in_sample = 16'd8;
        for (int c = 3; c < N; c++) begin
            chk("stall_ready", 32'(in_ready), 32'(c == N - 1));
            if (c < N - 1) tick();
        end
        tick();
        in_valid = 1'b0;
        chk("stall_accept_x", 32'(X), 32'd8);
        chk("stall_accept_first", 32'(mac_first), 32'd1);

        // write during RUN must not land
        coef_we = 1'b1;
        coef_addr = 3'd2;
        coef_wdata = 16'h7FFF;
        tick();
        coef_we = 1'b0;
        repeat (7) tick();
        chk("ignored_write_idle", 32'(busy), 32'd0);
        in_valid = 1'b1;
        in_sample = 16'd9;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("ignored_write_b", 32'(B), 32'd3);
        repeat (6) tick();
        chk("neg_idle", 32'(busy), 32'd0);

        // negative values, with the coefficient write on the transfer edge
        in_valid = 1'b1;
        in_sample = 16'h8000;
        coef_we = 1'b1;
        coef_addr = 3'd0;
        coef_wdata = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        coef_we = 1'b0;
        chk("neg_x", 32'(X), 32'h8000);
        chk("neg_b", 32'(B), 32'hFFFF);

        // asynchronous reset at cnt = 4
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_X", 32'(X), 32'd0);
        chk("rst_B", 32'(B), 32'd0);
        chk("rst_valid", 32'(mac_valid), 32'd0);
        chk("rst_first", 32'(mac_first), 32'd0);
        chk("rst_last", 32'(mac_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);
        chk("rst_release_busy", 32'(busy), 32'd0);
        in_valid = 1'b1;
        in_sample = 16'd5;
        tick();
        in_valid = 1'b0;
        chk("post_rst_x0", 32'(X), 32'd5);
        for (int k = 1; k < N; k++) begin
            tick();
            chk("post_rst_xk", 32'(X), 32'd0);
        end

        // random traffic against the model, with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            in_valid = $urandom_range(0, 3) != 0;
            in_sample = DW'($urandom);
            coef_we = $urandom_range(0, 3) == 0;
            coef_addr = 3'($urandom_range(0, N - 1));
            coef_wdata = DW'($urandom);
            tick();
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                model_check();
                #1;
                rst_n = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Upstream feed stage for the FIR multiply-accumulate ALU. Holds the sample delay line and the coefficient bank. For every accepted input sample, it walks all taps one per clock and presents the sample/coefficient pair on `X`/`B` with framing flags. The ALU's 39-bit accumulator uses these flags to clear on the first tap and to mark its result as complete on the last tap.

## Interface
Parameters:
- `NTAPS`, 8: number of filter taps; legal range 2..64.
- `DW`, 16: sample and coefficient width; must be 16 to match the ALU `X`/`B` ports.
- `AW`, `$clog2(NTAPS)`: tap index / coefficient address width (derived, do not override).

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  new sample offered.
- `in_ready`  out  1  sequencer can accept a sample this cycle.
- `in_sample`  in  DW  two's-complement input sample.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  AW  coefficient index; tap 0 multiplies the newest sample.
- `coef_wdata`  in  DW  two's-complement coefficient.
- `X`  out  DW  sample operand to the ALU.
- `B`  out  DW  coefficient operand to the ALU.
- `mac_valid`  out  1  `X`/`B` hold a live tap pair.
- `mac_first`  out  1  tap 0 of a sample; the ALU loads the product instead of accumulating.
- `mac_last`  out  1  tap NTAPS-1; the ALU sum is complete after this product.
- `busy`  out  1  state is RUN.

## Operation
- Storage:
  - Delay line `dl[0..NTAPS-1]`, DW bits each. `dl[0]` is the newest sample.
  - Coefficient bank `cf[0..NTAPS-1]`, DW bits each.
  - Tap counter `cnt`, AW bits.
  - State register: IDLE or RUN.
- Handshake: a transfer happens on a rising edge where `in_valid && in_ready`. On a transfer edge:
  - `dl[k] <= dl[k-1]` for k ≥ 1, and `dl[0] <= in_sample`.
  - `cnt <= 0`, state <= RUN.
- `in_ready`:
  - 1 in IDLE.
  - 1 in RUN only when `cnt == NTAPS-1`.
  - 0 otherwise, and 0 while `rst_n` is low.
- State transitions:
  - IDLE, no transfer -> stay IDLE.
  - IDLE, transfer -> RUN, `cnt` = 0.
  - RUN, `cnt < NTAPS-1` -> `cnt` increments.
  - RUN, `cnt == NTAPS-1`, transfer -> RUN, `cnt` = 0, delay line shifts. This is back-to-back operation with no bubble.
  - RUN, `cnt == NTAPS-1`, no transfer -> IDLE.
- Outputs, decoded from registered state only (no combinational path from inputs):
  - RUN: `X = dl[cnt]`, `B = cf[cnt]`, `mac_valid = 1`, `mac_first = (cnt == 0)`, `mac_last = (cnt == NTAPS-1)`, `busy = 1`.
  - IDLE: `X = 0`, `B = 0`, all flags 0.
- Coefficient writes:
  - A write with `coef_we` in IDLE updates `cf[coef_addr]` on the edge.
  - A write in RUN is ignored: the bank is unchanged and no error is flagged.
  - A write in IDLE on the same edge as a transfer is performed. The new value is used starting with the sample just accepted.
- No arithmetic is performed here. Values pass through bit-exact.
- Reset (`rst_n` low, asynchronous, including mid-RUN):
  - State -> IDLE, `cnt` = 0, all `dl` and `cf` = 0.
  - `X`, `B`, `mac_valid`, `mac_first`, `mac_last`, `busy`, `in_ready` = 0 immediately.
  - Any sample in progress is dropped; the partial ALU sum is abandoned.

## Timing
- Latency: transfer at edge E -> `mac_first` with tap 0 (the new sample) visible after E. `mac_last` is visible after edge E+NTAPS-1.
- Each sample occupies exactly NTAPS consecutive `mac_valid` cycles.
- Sustained throughput is one sample per NTAPS cycles when `in_valid` is held high.
- `mac_first` and `mac_last` each pulse exactly once per sample. They are never high in the same cycle, since NTAPS ≥ 2.
- The first `in_ready` after reset deassertion is in the same cycle, since the block is in IDLE.

## Test plan
- Impulse response:
  - Stimulus: write `cf` = 1..8 (NTAPS=8) in IDLE. Send sample 2, then seven samples of 0 with idle gaps.
  - Required response: for the sample that is the impulse's k-th successor, its tap-k cycle shows `X = 2`, `B = k+1`, and all other taps show `X = 0`.
- Back-to-back:
  - Stimulus: hold `in_valid` high with samples 10, 20, 30.
  - Required response: 24 consecutive `mac_valid` cycles, `mac_first` every 8 cycles, no bubble.
  - For the sample-30 pass: tap0 `X` = 30, tap1 `X` = 20, tap2 `X` = 10.
- Stall in RUN:
  - Stimulus: assert `in_valid` at `cnt` = 3.
  - Required response: `in_ready` = 0 and no transfer until the `cnt` = 7 cycle; acceptance happens on that edge.
- Ignored write:
  - Stimulus: write `cf[2]` = 0x7FFF during RUN, then send the next sample.
  - Required response: tap 2 still shows the old coefficient.
- Negative values:
  - Stimulus: sample 0x8000, coefficient 0xFFFF.
  - Required response: `X`/`B` carry 0x8000 and 0xFFFF bit-exact.
- Reset mid-RUN:
  - Stimulus: pull `rst_n` low at `cnt` = 4, without waiting for a clock edge.
  - Required response: all outputs 0 immediately; after release, IDLE with `in_ready` = 1.
  - A new sample 5 then yields `X` = 5, 0, 0, … because the delay line was cleared.
